// File: rtl/isdu.sv
// isdu: instruction sequencer and decode unit for the LC-3 datapath.
// Moore machine: fetch, decode, execute one instruction at a time.
//
// Ports:
//   Clk, Reset (async, active-low), Run, Continue  - control inputs
//   Opcode[3:0], IR_5, BEN                         - decode inputs
//   LD_*                                           - register load enables
//   Gate*                                          - bus drivers (one-hot or none)
//   PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
//   ADDR2MUX, ALUK                                 - datapath mux selects
//   Mem_CE/UB/LB/OE/WE                             - SRAM strobes, active-low
//
// state     | meaning
// ----------+--------------------------------------------
// HALTED    | idle after reset, waits for Run
// S_18      | MAR <- PC, PC <- PC+1
// S_33_1/2  | instruction read, MDR loaded in second cycle
// S_35      | IR <- MDR
// S_32      | decode, load BEN
// S_01/05/09| ADD / AND / NOT
// S_00      | BR, resolve on BEN
// S_22      | BR taken, PC <- PC+off9
// S_12      | JMP, PC <- SR1
// S_04      | JSR, R7 <- PC
// S_21      | JSR, PC <- PC+off11
// S_06/S_07 | LDR / STR, MAR <- SR1+off6
// S_25_1/2  | LDR data read, MDR loaded in second cycle
// S_27      | LDR, DR <- MDR
// S_23      | STR, MDR <- SR
// S_16_1/2  | STR write strobe
// PAUSE_1   | show LED, wait for Continue high
// PAUSE_2   | wait for Continue low

`timescale 1ns/1ps

module isdu (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S_18, S_33_1, S_33_2, S_35, S_32,
    S_01, S_05, S_09, S_00, S_22, S_12, S_04, S_21,
    S_06, S_25_1, S_25_2, S_27, S_07, S_23, S_16_1, S_16_2,
    PAUSE_1, PAUSE_2
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= HALTED;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALTED:  if (Run) state_d = S_18;
      S_18:    state_d = S_33_1;
      S_33_1:  state_d = S_33_2;
      S_33_2:  state_d = S_35;
      S_35:    state_d = S_32;
      S_32: begin
        unique case (Opcode)
          4'b0001: state_d = S_01;
          4'b0101: state_d = S_05;
          4'b1001: state_d = S_09;
          4'b0000: state_d = S_00;
          4'b1100: state_d = S_12;
          4'b0100: state_d = S_04;
          4'b0110: state_d = S_06;
          4'b0111: state_d = S_07;
          4'b1101: state_d = PAUSE_1;
          default: state_d = S_18;
        endcase
      end
      S_00:    state_d = BEN ? S_22 : S_18;
      S_04:    state_d = S_21;
      S_06:    state_d = S_25_1;
      S_25_1:  state_d = S_25_2;
      S_25_2:  state_d = S_27;
      S_07:    state_d = S_23;
      S_23:    state_d = S_16_1;
      S_16_1:  state_d = S_16_2;
      PAUSE_1: if (Continue)  state_d = PAUSE_2;
      PAUSE_2: if (!Continue) state_d = S_18;
      default: state_d = S_18;
    endcase
  end

  // Output decode from current state only
  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0;  LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = 2'b00; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; ALUK = 2'b00;
    Mem_CE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    unique case (state_q)
      S_18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = 2'b00;
      end
      S_33_1, S_25_1: Mem_OE = 1'b0;
      S_33_2, S_25_2: begin
        Mem_OE = 1'b0; LD_MDR = 1'b1;
      end
      S_35: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
      end
      S_32: LD_BEN = 1'b1;
      S_01, S_05, S_09: begin
        SR1MUX = 1'b1; SR2MUX = IR_5;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        ALUK = (state_q == S_01) ? 2'b00 : (state_q == S_05) ? 2'b01 : 2'b10;
      end
      S_22: begin
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      S_12: begin
        SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1;
        PCMUX = 2'b01; LD_PC = 1'b1;
      end
      S_04: begin
        GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
      end
      S_21: begin
        ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      S_06, S_07: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S_23: begin
        SR1MUX = 1'b0; ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
      end
      S_16_1, S_16_2: Mem_WE = 1'b0;
      PAUSE_1: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu.sv
// tb_isdu: directed bench for isdu. Each state is identified by its full
// control word, compared against hand-built constants.

`timescale 1ns/1ps

module tb_isdu;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, BEN;
  logic [3:0] Opcode;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  int n_checks = 0;
  int n_pass   = 0;

  isdu dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  // ld order: MAR MDR IR BEN CC REG PC LED; gate order: PC MDR ALU MARMUX
  function automatic logic [26:0] cw(input logic [7:0] ld, input logic [3:0] gate,
                                     input logic [1:0] pcmux, input logic dr,
                                     input logic sr1, input logic sr2, input logic a1,
                                     input logic [1:0] a2, input logic [1:0] aluk,
                                     input logic oe, input logic we);
    return {ld, gate, pcmux, dr, sr1, sr2, a1, a2, aluk, 3'b000, oe, we};
  endfunction

  logic [26:0] ctl;
  assign ctl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                ADDR1MUX, ADDR2MUX, ALUK, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};

  logic [26:0] W_DEF, W_18, W_33_1, W_33_2, W_35, W_32, W_01_I, W_05_R, W_09;
  logic [26:0] W_22, W_12, W_04, W_21, W_06, W_27, W_23, W_16, W_P1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Current state is S_18; walk the fetch and land in S_32.
  task automatic fetch(input string tag);
    chk({tag, "_s18"}, {5'd0, ctl}, {5'd0, W_18});
    tick(); chk({tag, "_s33_1"}, {5'd0, ctl}, {5'd0, W_33_1});
    tick(); chk({tag, "_s33_2"}, {5'd0, ctl}, {5'd0, W_33_2});
    tick(); chk({tag, "_s35"},   {5'd0, ctl}, {5'd0, W_35});
    tick(); chk({tag, "_s32"},   {5'd0, ctl}, {5'd0, W_32});
  endtask

  task automatic expect_w(input string tag, input logic [26:0] w);
    tick();
    chk(tag, {5'd0, ctl}, {5'd0, w});
  endtask

  initial begin
    W_DEF  = cw(8'b0000_0000, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    W_18   = cw(8'b1000_0010, 4'b1000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    W_33_1 = cw(8'b0000_0000, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    W_33_2 = cw(8'b0100_0000, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    W_35   = cw(8'b0010_0000, 4'b0100, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    W_32   = cw(8'b0001_0000, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    W_01_I = cw(8'b0000_1100, 4'b0010, 2'b00, 0, 1, 1, 0, 2'b00, 2'b00, 1, 1);
    W_05_R = cw(8'b0000_1100, 4'b0010, 2'b00, 0, 1, 0, 0, 2'b00, 2'b01, 1, 1);
    W_09   = cw(8'b0000_1100, 4'b0010, 2'b00, 0, 1, 1, 0, 2'b00, 2'b10, 1, 1);
    W_22   = cw(8'b0000_0010, 4'b0000, 2'b10, 0, 0, 0, 0, 2'b10, 2'b00, 1, 1);
    W_12   = cw(8'b0000_0010, 4'b0010, 2'b01, 0, 1, 0, 0, 2'b00, 2'b11, 1, 1);
    W_04   = cw(8'b0000_0100, 4'b1000, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    W_21   = cw(8'b0000_0010, 4'b0000, 2'b10, 0, 0, 0, 0, 2'b11, 2'b00, 1, 1);
    W_06   = cw(8'b1000_0000, 4'b0001, 2'b00, 0, 1, 0, 1, 2'b01, 2'b00, 1, 1);
    W_27   = cw(8'b0000_1100, 4'b0100, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    W_23   = cw(8'b0100_0000, 4'b0010, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 1, 1);
    W_16   = cw(8'b0000_0000, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    W_P1   = cw(8'b0000_0001, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);

    Reset = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0000; IR_5 = 1'b0; BEN = 1'b0;
    #2;
    chk("reset_defaults", {5'd0, ctl}, {5'd0, W_DEF});
    Reset = 1'b1;
    tick(); tick();
    chk("halted_no_run", {5'd0, ctl}, {5'd0, W_DEF});
    Run = 1'b1;
    expect_w("run_s18", W_18);
    expect_w("pre_rst_s33_1", W_33_1);
    // Asynchronous reset in the middle of the fetch read
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_oe", {31'd0, Mem_OE}, 32'd1);
    chk("async_rst_word", {5'd0, ctl}, {5'd0, W_DEF});
    Run = 1'b0;
    #3 Reset = 1'b1;
    tick();
    chk("halted_after_rst", {5'd0, ctl}, {5'd0, W_DEF});
    Run = 1'b1;
    expect_w("restart_s18", W_18);
    Run = 1'b0;

    // ADD immediate: 6 cycles
    Opcode = 4'b0001; IR_5 = 1'b1;
    fetch("add");
    expect_w("add_s01", W_01_I);
    expect_w("add_back_s18", W_18);

    // AND register
    Opcode = 4'b0101; IR_5 = 1'b0;
    fetch("and");
    expect_w("and_s05", W_05_R);
    expect_w("and_back_s18", W_18);

    // NOT (IR_5 forwarded to SR2MUX)
    Opcode = 4'b1001; IR_5 = 1'b1;
    fetch("not");
    expect_w("not_s09", W_09);
    expect_w("not_back_s18", W_18);

    // BR taken
    Opcode = 4'b0000; BEN = 1'b1;
    fetch("brt");
    expect_w("brt_s00", W_DEF);
    expect_w("brt_s22", W_22);
    expect_w("brt_back_s18", W_18);

    // BR not taken
    BEN = 1'b0;
    fetch("brn");
    expect_w("brn_s00", W_DEF);
    expect_w("brn_back_s18", W_18);

    // JMP
    Opcode = 4'b1100;
    fetch("jmp");
    expect_w("jmp_s12", W_12);
    expect_w("jmp_back_s18", W_18);

    // JSR
    Opcode = 4'b0100;
    fetch("jsr");
    expect_w("jsr_s04", W_04);
    expect_w("jsr_s21", W_21);
    expect_w("jsr_back_s18", W_18);

    // LDR: OE low exactly 2 cycles
    Opcode = 4'b0110;
    fetch("ldr");
    expect_w("ldr_s06", W_06);
    tick(); chk("ldr_oe1", {29'd0, Mem_CE, Mem_OE, Mem_WE}, 32'b001);
    tick(); chk("ldr_oe2", {29'd0, Mem_CE, Mem_OE, Mem_WE}, 32'b001);
    expect_w("ldr_s27", W_27);
    expect_w("ldr_back_s18", W_18);

    // STR: WE low exactly 2 cycles
    Opcode = 4'b0111;
    fetch("str");
    expect_w("str_s07", W_06);
    expect_w("str_s23", W_23);
    expect_w("str_we1", W_16);
    expect_w("str_we2", W_16);
    expect_w("str_back_s18", W_18);

    // PAUSE with Continue high for 3 cycles
    Opcode = 4'b1101;
    fetch("pause");
    expect_w("pause_p1", W_P1);
    expect_w("pause_p1_hold", W_P1);
    Continue = 1'b1;
    expect_w("pause_p2", W_DEF);
    expect_w("pause_p2_hold1", W_DEF);
    expect_w("pause_p2_hold2", W_DEF);
    Continue = 1'b0;
    expect_w("pause_back_s18", W_18);

    // PAUSE entered with Continue already high
    Continue = 1'b1;
    fetch("pause_hi");
    expect_w("pause_hi_p1", W_P1);
    expect_w("pause_hi_p2", W_DEF);
    Continue = 1'b0;
    expect_w("pause_hi_back_s18", W_18);

    // Illegal opcode is a NOP
    Opcode = 4'b1111;
    fetch("ill");
    expect_w("ill_back_s18", W_18);

    // Run held high outside HALTED does nothing
    Run = 1'b1; Opcode = 4'b0001; IR_5 = 1'b0;
    fetch("runhi");
    expect_w("runhi_s01", cw(8'b0000_1100, 4'b0010, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 1, 1));
    expect_w("runhi_back_s18", W_18);
    Run = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
